// File: rtl/usb_tx_pkg.sv
// ============================================================================
//  Module      : usb_tx_pkg
//  Description : Shared types and constants for the USB transmit encoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_STUFF = 3'd3,
        ST_EOP1  = 3'd4,
        ST_EOP2  = 3'd5,
        ST_EOP_J = 3'd6
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE        = 8'h80;
    localparam logic [2:0] STUFF_LIMIT      = 3'd6;
    localparam logic [3:0] BIT_PERIOD_SHORT = 4'd8;
    localparam logic [3:0] BIT_PERIOD_LONG  = 4'd9;
    localparam logic [1:0] LONG_PHASE       = 2'd2;

    // Terminal count of the bit-period counter for the given 8,8,9 phase.
    function automatic logic [3:0] bit_period_last(input logic [1:0] phase);
        return ((phase == LONG_PHASE) ? BIT_PERIOD_LONG : BIT_PERIOD_SHORT) - 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/flex_counter.sv
// ============================================================================
//  Module      : flex_counter
//  Description : Enabled up-counter that wraps to zero after rollover_val.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    localparam logic [NUM_CNT_BITS-1:0] C_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    logic [NUM_CNT_BITS-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            r_count <= (r_count == rollover_val) ? '0 : r_count + C_ONE;
        end
    end

    assign count_out = r_count;

endmodule

`default_nettype wire

// File: rtl/usb_tx_encoder.sv
// ============================================================================
//  Module      : usb_tx_encoder
//  Description : USB full-speed transmit path: SYNC, bit stuffing, NRZI, EOP.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module usb_tx_encoder
    import usb_tx_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    tx_state_t  r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_hold, w_hold_nxt;
    logic       r_hold_full, w_hold_full_nxt;
    logic       r_hold_last, w_hold_last_nxt;
    logic       r_cur_last, w_cur_last_nxt;
    logic [2:0] r_ones, w_ones_nxt;
    logic [1:0] r_phase, w_phase_nxt;
    logic       r_dp, w_dp_nxt;
    logic       r_dm, w_dm_nxt;
    logic       r_err_seen, w_err_seen_nxt;
    logic       r_done, w_done_nxt;
    logic       r_err, w_err_nxt;

    logic [3:0] w_bit_cnt;
    logic [2:0] w_bit_idx;
    logic [2:0] w_idx_next;
    logic       w_busy;
    logic       w_strobe;
    logic       w_byte_end;
    logic       w_in_eop;
    logic       w_accept;
    logic       w_advance;
    logic       w_idx_adv;
    logic       w_send;
    logic       w_send_bit;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_strobe   = w_busy && (w_bit_cnt == bit_period_last(r_phase));
    assign w_byte_end = (w_bit_idx == 3'd7);
    assign w_idx_next = w_bit_idx + 3'd1;
    assign w_in_eop   = (r_state == ST_EOP1) || (r_state == ST_EOP2) || (r_state == ST_EOP_J);
    assign tx_ready   = !r_hold_full && !w_in_eop;
    assign w_accept   = tx_valid && tx_ready;

    flex_counter #(.NUM_CNT_BITS(4)) u_bit_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!w_busy),
        .count_enable (w_busy),
        .rollover_val (bit_period_last(r_phase)),
        .count_out    (w_bit_cnt)
    );

    flex_counter #(.NUM_CNT_BITS(3)) u_idx_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!w_busy),
        .count_enable (w_idx_adv),
        .rollover_val (3'd7),
        .count_out    (w_bit_idx)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_hold_last <= 1'b0;
            r_cur_last  <= 1'b0;
            r_ones      <= '0;
            r_phase     <= '0;
            r_dp        <= 1'b1;
            r_dm        <= 1'b0;
            r_err_seen  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_hold_last <= w_hold_last_nxt;
            r_cur_last  <= w_cur_last_nxt;
            r_ones      <= w_ones_nxt;
            r_phase     <= w_phase_nxt;
            r_dp        <= w_dp_nxt;
            r_dm        <= w_dm_nxt;
            r_err_seen  <= w_err_seen_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_hold_last_nxt = r_hold_last;
        w_cur_last_nxt  = r_cur_last;
        w_ones_nxt      = r_ones;
        w_phase_nxt     = r_phase;
        w_dp_nxt        = r_dp;
        w_dm_nxt        = r_dm;
        w_err_seen_nxt  = r_err_seen;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_advance       = 1'b0;
        w_idx_adv       = 1'b0;
        w_send          = 1'b0;
        w_send_bit      = 1'b0;

        if (w_accept) begin
            w_hold_nxt      = tx_data;
            w_hold_last_nxt = tx_last;
            w_hold_full_nxt = 1'b1;
        end

        if (!w_busy) begin
            w_phase_nxt = '0;
        end else if (w_strobe) begin
            w_phase_nxt = (r_phase == LONG_PHASE) ? 2'd0 : r_phase + 2'd1;
        end

        case (r_state)
            ST_IDLE: begin
                w_ones_nxt = '0;
                if (r_hold_full) begin
                    w_state_nxt    = ST_SYNC;
                    w_shift_nxt    = SYNC_BYTE;
                    w_cur_last_nxt = 1'b0;
                    w_err_seen_nxt = 1'b0;
                    w_send         = 1'b1;
                    w_send_bit     = SYNC_BYTE[0];
                end
            end
            ST_SYNC, ST_DATA: begin
                if (w_strobe) begin
                    if (r_ones == STUFF_LIMIT) begin
                        w_state_nxt = ST_STUFF;
                        w_dp_nxt    = r_dm;
                        w_dm_nxt    = r_dp;
                        w_ones_nxt  = '0;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            ST_STUFF: begin
                if (w_strobe) begin
                    w_advance = 1'b1;
                end
            end
            ST_EOP1: begin
                w_ones_nxt = '0;
                if (w_strobe) begin
                    w_state_nxt = ST_EOP2;
                end
            end
            ST_EOP2: begin
                if (w_strobe) begin
                    w_state_nxt = ST_EOP_J;
                    w_dp_nxt    = 1'b1;
                    w_dm_nxt    = 1'b0;
                end
            end
            ST_EOP_J: begin
                if (w_strobe) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = !r_err_seen;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_dp_nxt    = 1'b1;
                w_dm_nxt    = 1'b0;
            end
        endcase

        // Stuff bits never advance the index, so the byte boundary is handled here for both paths.
        if (w_advance) begin
            w_idx_adv = 1'b1;
            if (!w_byte_end) begin
                w_state_nxt = (r_state == ST_STUFF) ? ST_DATA : r_state;
                w_send      = 1'b1;
                w_send_bit  = r_shift[w_idx_next];
            end else if (r_cur_last) begin
                w_state_nxt = ST_EOP1;
                w_dp_nxt    = 1'b0;
                w_dm_nxt    = 1'b0;
            end else if (r_hold_full) begin
                w_state_nxt     = ST_DATA;
                w_shift_nxt     = r_hold;
                w_cur_last_nxt  = r_hold_last;
                w_hold_full_nxt = 1'b0;
                w_send          = 1'b1;
                w_send_bit      = r_hold[0];
            end else begin
                w_state_nxt    = ST_EOP1;
                w_dp_nxt       = 1'b0;
                w_dm_nxt       = 1'b0;
                w_err_nxt      = 1'b1;
                w_err_seen_nxt = 1'b1;
            end
        end

        if (w_send) begin
            if (w_send_bit) begin
                w_ones_nxt = r_ones + 3'd1;
            end else begin
                w_dp_nxt   = r_dm;
                w_dm_nxt   = r_dp;
                w_ones_nxt = '0;
            end
        end
    end

    assign d_plus  = r_dp;
    assign d_minus = r_dm;
    assign tx_busy = w_busy;
    assign tx_done = r_done;
    assign tx_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_usb_tx_encoder.sv
// ============================================================================
//  Module      : tb_usb_tx_encoder
//  Description : Self-checking bench for usb_tx_encoder against a bit-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_usb_tx_encoder;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_bytes[$];
    logic [1:0] exp_sym[$];
    logic [1:0] line_q[$];

    usb_tx_encoder dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err)
    );

    always #5 clk = ~clk;

    function automatic int period_len(input int k);
        return (k % 3 == 2) ? 9 : 8;
    endfunction

    // Expected line level per bit period: raw bits -> stuffing -> NRZI -> EOP.
    task automatic build_expect();
        logic [7:0] v;
        bit         stream[$];
        logic [1:0] lvl;
        int         ones;
        exp_sym.delete();
        v = 8'h80;
        for (int i = 0; i < 8; i++) stream.push_back(v[i]);
        foreach (q_bytes[b]) begin
            v = q_bytes[b];
            for (int i = 0; i < 8; i++) stream.push_back(v[i]);
        end
        lvl  = 2'b10;
        ones = 0;
        foreach (stream[i]) begin
            if (stream[i] == 1'b0) begin
                lvl  = ~lvl;
                ones = 0;
            end else begin
                ones++;
            end
            exp_sym.push_back(lvl);
            if (ones == 6) begin
                lvl  = ~lvl;
                ones = 0;
                exp_sym.push_back(lvl);
            end
        end
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b10);
    endtask

    task automatic run_packet(input bit underrun, input string name);
        int n, idx, dones, errs, err_at, total, pos, eop_at;
        bit started, acc, prev_acc, finished, ok;
        logic [1:0] got;
        build_expect();
        n = q_bytes.size();
        idx = 0; dones = 0; errs = 0; err_at = -1;
        started = 0; prev_acc = 0; finished = 0;
        line_q.delete();
        tx_valid = 1'b1;
        tx_data  = q_bytes[0];
        tx_last  = (n == 1) && !underrun;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            if (prev_acc) begin
                checks++;
                if (tx_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_after_accept: got %b want 0", name, tx_ready);
                end
            end
            if (tx_done === 1'b1) dones++;
            if (tx_err === 1'b1) begin
                errs++;
                err_at = line_q.size();
            end
            if (tx_busy === 1'b1) begin
                started = 1;
                line_q.push_back({d_plus, d_minus});
            end else if (started) begin
                finished = 1;
            end
            acc = (tx_valid === 1'b1) && (tx_ready === 1'b1);
            prev_acc = acc;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < n) begin
                    tx_data = q_bytes[idx];
                    tx_last = (idx == n - 1) && !underrun;
                end else begin
                    tx_valid = 1'b0;
                    tx_last  = 1'b0;
                end
            end
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;

        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: busy_seen %0d want packet end", name, started);
        end
        total = 0;
        foreach (exp_sym[k]) total += period_len(k);
        checks++;
        if (line_q.size() != total) begin
            errors++;
            $display("FAIL %s busy_clocks: got %0d want %0d", name, line_q.size(), total);
        end
        pos = 0;
        foreach (exp_sym[k]) begin
            ok  = 1;
            got = exp_sym[k];
            for (int j = 0; j < period_len(k); j++) begin
                if (pos + j >= line_q.size()) begin
                    ok  = 0;
                    got = 2'bxx;
                end else if (line_q[pos + j] !== exp_sym[k]) begin
                    ok  = 0;
                    got = line_q[pos + j];
                end
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s period_%0d line: got %b want %b", name, k, got, exp_sym[k]);
            end
            pos += period_len(k);
        end
        checks++;
        if (dones != (underrun ? 0 : 1)) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want %0d", name, dones, underrun ? 0 : 1);
        end
        checks++;
        if (errs != (underrun ? 1 : 0)) begin
            errors++;
            $display("FAIL %s err_pulses: got %0d want %0d", name, errs, underrun ? 1 : 0);
        end
        if (underrun) begin
            eop_at = 0;
            for (int k = 0; k < exp_sym.size() - 3; k++) eop_at += period_len(k);
            checks++;
            if (err_at != eop_at) begin
                errors++;
                $display("FAIL %s err_time: got %0d want %0d", name, err_at, eop_at);
            end
        end
    endtask

    task automatic offer_byte(input logic [7:0] d, input bit last, input string name);
        bit got;
        got = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = last;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) got = 1;
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s accept: got none want accepted", name);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err} !== 6'b101000) begin
            errors++;
            $display("FAIL reset_state: got %b want 101000",
                     {d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err});
        end
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({d_plus, d_minus, tx_ready, tx_busy} !== 4'b1010) begin
            errors++;
            $display("FAIL idle_state: got %b want 1010", {d_plus, d_minus, tx_ready, tx_busy});
        end
    endtask

    task automatic test_single_zero();
        q_bytes = '{8'h00};
        run_packet(1'b0, "byte_00");
        checks++;
        if (line_q.size() != 158) begin
            errors++;
            $display("FAIL byte_00 total_clocks: got %0d want 158", line_q.size());
        end
    endtask

    task automatic test_single_ff();
        q_bytes = '{8'hFF};
        run_packet(1'b0, "byte_ff");
        checks++;
        if (line_q.size() != 166) begin
            errors++;
            $display("FAIL byte_ff total_clocks: got %0d want 166", line_q.size());
        end
    endtask

    task automatic test_back_to_back();
        q_bytes = '{8'hA5, 8'h3C};
        run_packet(1'b0, "back_to_back");
    endtask

    task automatic test_underrun();
        q_bytes = '{8'h01};
        run_packet(1'b1, "underrun");
    endtask

    task automatic test_mid_reset();
        bit stayed_idle;
        offer_byte(8'h5A, 1'b0, "mid_reset_b0");
        offer_byte(8'hC3, 1'b1, "mid_reset_b1");
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset pre_busy: got %b want 1", tx_busy);
        end
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err} !== 6'b101000) begin
            errors++;
            $display("FAIL mid_reset state: got %b want 101000",
                     {d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err});
        end
        n_rst = 1'b1;
        stayed_idle = 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if ({d_plus, d_minus, tx_busy, tx_done, tx_err} !== 5'b10000) stayed_idle = 0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (!stayed_idle) begin
            errors++;
            $display("FAIL mid_reset no_eop: got activity want idle J");
        end
        q_bytes = '{8'h7E, 8'hFF};
        run_packet(1'b0, "after_reset");
    endtask

    task automatic test_random();
        int n;
        for (int p = 0; p < 6; p++) begin
            n = $urandom_range(1, 4);
            q_bytes.delete();
            for (int i = 0; i < n; i++) begin
                q_bytes.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            run_packet(($urandom_range(0, 4) == 0), "random");
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_zero();
        repeat (3) @(posedge clk);
        #1;
        test_single_ff();
        repeat (3) @(posedge clk);
        #1;
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        test_underrun();
        repeat (3) @(posedge clk);
        #1;
        test_mid_reset();
        repeat (3) @(posedge clk);
        #1;
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
